// File: rtl/pipe_adder_pkg.sv
// Shared constants, configuration check and stage record for the pipelined slice adder.
// The optional subtract path is enabled by defining PIPE_ADDER_SUB_EN.
package pipe_adder_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 4;
  // Widest operand the stage record can carry; narrower builds use the low bits.
  localparam int WIDTH_MAX = 64;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [WIDTH_MAX-1:0] sum;
    logic [WIDTH_MAX-1:0] a;
    logic [WIDTH_MAX-1:0] b;
  } stage_t;

  function automatic bit cfg_ok(input int width, input int slice);
    bit ok;
    ok = 1'b0;
    if ((slice >= 32'sd1) && (width >= slice) && (width <= WIDTH_MAX)) begin
      ok = ((width % slice) == 32'sd0);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; in_sub exists only when
// PIPE_ADDER_SUB_EN is defined.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin,
`ifdef PIPE_ADDER_SUB_EN
    output in_sub,
`endif
    input  in_ready,
    output out_ready,
    input  out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
`ifdef PIPE_ADDER_SUB_EN
    input  in_sub,
`endif
    output in_ready,
    input  out_ready,
    output out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/pipe_adder_slice.sv
// adder_slice: SLICE-bit ripple-carry adder, also exposing the carry into its MSB
// so the final stage can derive signed overflow.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Bit-serial carry ripple across the slice.
  always_comb begin
    logic [SLICE:0] c;
    c     = '0;
    sum   = '0;
    c[0]  = cin;
    for (int k = 0; k < SLICE; k++) begin
      sum[k]   = a[k] ^ b[k] ^ c[k];
      c[k + 1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end
    cout  = c[SLICE];
    c_msb = c[SLICE - 1];
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: one ripple slice per stage, carry registered between stages, global stall.
// Define PIPE_ADDER_SUB_EN to add the in_sub subtract select.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input logic         clk,
  input logic         rst_n,
  pipe_adder_if.slave bus
);

  localparam int STAGES = WIDTH / SLICE;

  if (!cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
    $error("pipe_adder: WIDTH must be a positive multiple of SLICE and at most WIDTH_MAX");
  end

  stage_t            stage_r [STAGES];
  stage_t            next_s  [STAGES];
  logic              ovf_r;
  logic              en_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic              cin_eff_s;
  logic [SLICE-1:0]  sa_s [STAGES];
  logic [SLICE-1:0]  sb_s [STAGES];
  logic [SLICE-1:0]  ss_s [STAGES];
  logic [STAGES-1:0] ci_s;
  logic [STAGES-1:0] co_s;
  logic [STAGES-1:0] cm_s;
  logic              unused_s;

  assign en_s         = !stage_r[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready = en_s;

`ifdef PIPE_ADDER_SUB_EN
  assign b_eff_s   = bus.in_b ^ {WIDTH{bus.in_sub}};
  assign cin_eff_s = bus.in_cin ^ bus.in_sub;
`else
  assign b_eff_s   = bus.in_b;
  assign cin_eff_s = bus.in_cin;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign sa_s[i] = bus.in_a[SLICE-1:0];
      assign sb_s[i] = b_eff_s[SLICE-1:0];
      assign ci_s[i] = cin_eff_s;
    end else begin : g_body
      assign sa_s[i] = stage_r[i-1].a[i*SLICE +: SLICE];
      assign sb_s[i] = stage_r[i-1].b[i*SLICE +: SLICE];
      assign ci_s[i] = stage_r[i-1].carry;
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
      .a     (sa_s[i]),
      .b     (sb_s[i]),
      .cin   (ci_s[i]),
      .sum   (ss_s[i]),
      .cout  (co_s[i]),
      .c_msb (cm_s[i])
    );
  end

  // Each stage inherits the previous record and fills in its own sum slice and carry.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      next_s[i] = '0;
    end
    next_s[0].valid              = bus.in_valid;
    next_s[0].a[WIDTH-1:0]       = bus.in_a;
    next_s[0].b[WIDTH-1:0]       = b_eff_s;
    next_s[0].sum[SLICE-1:0]     = ss_s[0];
    next_s[0].carry              = co_s[0];
    for (int i = 1; i < STAGES; i++) begin
      next_s[i]                       = stage_r[i-1];
      next_s[i].sum[i*SLICE +: SLICE] = ss_s[i];
      next_s[i].carry                 = co_s[i];
    end
  end

  // Pipeline registers: synchronous clear, all stages advance together on en_s.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
      ovf_r <= 1'b0;
    end else if (en_s) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= next_s[i];
      end
      ovf_r <= cm_s[STAGES-1] ^ co_s[STAGES-1];
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign bus.out_valid = stage_r[STAGES-1].valid;
  assign bus.out_sum   = stage_r[STAGES-1].sum[WIDTH-1:0];
  assign bus.out_cout  = stage_r[STAGES-1].carry;
  assign bus.out_ovf   = ovf_r;

  // Operand remainders are exhausted at the last stage and only its MSB carry matters.
  assign unused_s = ^{stage_r[STAGES-1].a, stage_r[STAGES-1].b, stage_r[STAGES-1].sum, cm_s};

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=32, SLICE=4): directed cases plus random
// streams scored against an arithmetic reference model; covers PIPE_ADDER_SUB_EN builds.
module tb_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 4;
  localparam int STAGES = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks    = 0;
  int          errors    = 0;
  int          accepted  = 0;
  int          delivered = 0;
  logic        sub_v     = 1'b0;
  logic        use_dir   = 1'b0;
  logic [33:0] dir_exp   = '0;
  logic [33:0] exp_q [$];

  // Expected {ovf, cout, sum} from plain arithmetic on the operands.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] bb;
    logic [32:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, cin ^ sub};
    ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
    return {ovf, full[32], full[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    sub_v        = sub;
`ifdef PIPE_ADDER_SUB_EN
    bus.in_sub   = sub;
`endif
  endtask

  // Score the handshake at this negedge, then advance one clock.
  task automatic cycle();
    logic [33:0] e;
    #1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {30'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, {30'd0, e});
          delivered++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(use_dir ? dir_exp : model(bus.in_a, bus.in_b, bus.in_cin, sub_v));
        accepted++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One directed operation into an empty pipe: checks latency and the hand-derived result.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [33:0] exp);
    int lat;
    use_dir = 1'b1;
    dir_exp = exp;
    drive(1'b1, a, b, cin, sub);
    cycle();
    use_dir = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(STAGES - 1));
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int d0;
    logic s;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum",   64'(bus.out_sum),   64'd0);
    check("rst_out_cout",  64'(bus.out_cout),  64'd0);
    check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);

    single("wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    single("ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    single("cin",  32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0010});
`ifdef PIPE_ADDER_SUB_EN
    single("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    single("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0002});
`endif

    // Back-to-back stream: one accept and, once full, one result every cycle.
    d0 = delivered;
    for (int n = 0; n < 100; n++) begin
`ifdef PIPE_ADDER_SUB_EN
      s = 1'($urandom_range(1, 0));
`else
      s = 1'b0;
`endif
      drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(1, 0)), s);
      check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      cycle();
    end
    check("stream_throughput", 64'(delivered - d0), 64'(100 - STAGES));
    check("stream_in_flight",  64'(exp_q.size()),   64'(STAGES));

    // Backpressure on a full pipe: no accept, outputs held at the oldest result.
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(1, 0)), 1'b0);
      #1;
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold", {30'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, {30'd0, exp_q[0]});
      cycle();
    end
    check("bp_no_accept", 64'(exp_q.size()), 64'(STAGES));
    bus.out_ready = 1'b1;

    // Random valid/ready mix, then drain.
    for (int n = 0; n < 150; n++) begin
`ifdef PIPE_ADDER_SUB_EN
      s = 1'($urandom_range(1, 0));
`else
      s = 1'b0;
`endif
      drive(1'($urandom_range(1, 0)), $urandom(), $urandom(), 1'($urandom_range(1, 0)), s);
      bus.out_ready = 1'($urandom_range(1, 0));
      cycle();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
      cycle();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(delivered),    64'(accepted));

    // Reset with four operations in flight: nothing may emerge afterwards.
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int n = 0; n < STAGES; n++) begin
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      cycle();
    end

    single("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345_678A});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
